// File: rtl/imem_loader_pkg.sv
// Shared constants, state encoding and helpers for the UART instruction-memory loader.
package imem_loader_pkg;

  localparam int unsigned DefaultMemBytes = 1024;
  localparam logic [7:0]  DefaultSyncByte = 8'hA5;

  typedef logic [2:0] state_t;

  localparam state_t StIdle = 3'd0;
  localparam state_t StLen0 = 3'd1;
  localparam state_t StLen1 = 3'd2;
  localparam state_t StData = 3'd3;
  localparam state_t StCsum = 3'd4;
  localparam state_t StErr  = 3'd5;

  // A frame must carry at least one word and fit inside the memory.
  function automatic logic len_ok(input logic [15:0] len, input int unsigned mem_bytes);
    return (len != 16'd0) && ({16'd0, len} <= 32'(mem_bytes / 4));
  endfunction

endpackage

// File: rtl/imem_loader_packer.sv
// Little-endian byte-to-word packer; word_valid pulses the cycle after the 4th byte.
module byte_word_packer (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        word_valid,
  output logic [31:0] word
);

  logic [1:0]  cnt_q;
  logic [31:0] word_q;
  logic        valid_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q   <= 2'd0;
      word_q  <= 32'd0;
      valid_q <= 1'b0;
    end else if (clear) begin
      cnt_q   <= 2'd0;
      valid_q <= 1'b0;
    end else if (byte_valid) begin
      // Shift down so the first byte of a group ends up in bits [7:0].
      word_q  <= {byte_data, word_q[31:8]};
      cnt_q   <= cnt_q + 2'd1;
      valid_q <= (cnt_q == 2'd3);
    end else begin
      valid_q <= 1'b0;
    end
  end

  assign word_valid = valid_q;
  assign word       = word_q;

endmodule

// File: rtl/imem_loader.sv
// Loads a framed program image from a UART byte stream into instruction memory.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int unsigned MEM_BYTES      = DefaultMemBytes,
  parameter logic [7:0]  SYNC_BYTE      = DefaultSyncByte,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        cpu_hold,
  output logic        done,
  output logic        error
);

  state_t      state_q, state_d;
  logic [15:0] len_q, len_d;
  logic [15:0] word_cnt_q, word_cnt_d;
  logic [7:0]  csum_q, csum_d;
  logic [31:0] tmo_q, tmo_d;
  logic        done_q, done_d;
  logic        clear;
  logic        accept;
  logic        in_frame;
  logic        pk_valid;
  logic [31:0] pk_word;

  assign rx_ready = !pk_valid;
  assign accept   = rx_valid && rx_ready;
  assign in_frame = (state_q == StLen0) || (state_q == StLen1) ||
                    (state_q == StData) || (state_q == StCsum);

  byte_word_packer u_packer (
    .clk        (clk),
    .reset      (reset),
    .clear      (clear),
    .byte_valid (accept && (state_q == StData)),
    .byte_data  (rx_data),
    .word_valid (pk_valid),
    .word       (pk_word)
  );

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    word_cnt_d = word_cnt_q;
    csum_d     = csum_q;
    tmo_d      = tmo_q;
    done_d     = 1'b0;
    clear      = 1'b0;

    case (state_q)
      StIdle, StErr: begin
        if (accept && (rx_data == SYNC_BYTE)) begin
          state_d    = StLen0;
          clear      = 1'b1;
          len_d      = 16'd0;
          word_cnt_d = 16'd0;
          csum_d     = 8'd0;
          tmo_d      = 32'd0;
        end
      end
      StLen0: begin
        if (accept) begin
          len_d[7:0] = rx_data;
          state_d    = StLen1;
        end
      end
      StLen1: begin
        if (accept) begin
          len_d[15:8] = rx_data;
          state_d     = len_ok({rx_data, len_q[7:0]}, MEM_BYTES) ? StData : StErr;
        end
      end
      StData: begin
        if (accept) begin
          csum_d = csum_q ^ rx_data;
        end
        if (pk_valid) begin
          word_cnt_d = word_cnt_q + 16'd1;
          if (word_cnt_q == len_q - 16'd1) begin
            state_d = StCsum;
          end
        end
      end
      StCsum: begin
        if (accept) begin
          if (rx_data == csum_q) begin
            state_d = StIdle;
            done_d  = 1'b1;
          end else begin
            state_d = StErr;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    // Inter-byte watchdog; the write cycle counts as idle since no byte can land then.
    if (in_frame) begin
      if (accept) begin
        tmo_d = 32'd0;
      end else if (tmo_q >= 32'(TIMEOUT_CYCLES - 1)) begin
        state_d = StErr;
        tmo_d   = 32'd0;
      end else begin
        tmo_d = tmo_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= StIdle;
      len_q      <= 16'd0;
      word_cnt_q <= 16'd0;
      csum_q     <= 8'd0;
      tmo_q      <= 32'd0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      word_cnt_q <= word_cnt_d;
      csum_q     <= csum_d;
      tmo_q      <= tmo_d;
      done_q     <= done_d;
    end
  end

  assign mem_we    = pk_valid;
  assign mem_addr  = {14'd0, word_cnt_q, 2'b00};
  assign mem_wdata = pk_word;
  assign done      = done_q;
  assign error     = (state_q == StErr);
  // Hold stays up through the done pulse, which lands in the cycle after leaving CSUM.
  assign cpu_hold  = (state_q != StIdle) || done_q;

endmodule

// File: tb/tb_imem_loader.sv
// Scenario bench for imem_loader: expected writes go to a scoreboard checked on mem_we.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [7:0]  rx_data = 8'd0;
  logic        rx_valid = 1'b0;
  logic        rx_ready, mem_we, cpu_hold, done, error;
  logic [31:0] mem_addr, mem_wdata;

  int tests_run = 0;
  int fails = 0;
  int done_cycles = 0;
  logic [63:0] exp_q[$];

  logic [7:0] good_frame[$] = '{8'hA5, 8'h02, 8'h00, 8'h93, 8'h00, 8'hA0, 8'h00,
                                8'h13, 8'h01, 8'h40, 8'h01, 8'h60};

  imem_loader #(.MEM_BYTES(1024), .SYNC_BYTE(8'hA5), .TIMEOUT_CYCLES(100)) dut (
    .clk       (clk),
    .reset     (reset),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .cpu_hold  (cpu_hold),
    .done      (done),
    .error     (error)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Scoreboard: every write strobe must match the oldest expected (addr, data).
  always @(negedge clk) begin
    if (done) done_cycles++;
    if (mem_we) begin
      logic [63:0] e;
      tests_run++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL write_unexpected: got addr=%h data=%h, required no write",
                 mem_addr, mem_wdata);
      end else begin
        e = exp_q.pop_front();
        if ({mem_addr, mem_wdata} !== e || rx_ready !== 1'b0) begin
          fails++;
          $display("FAIL write: got addr=%h data=%h ready=%b, required addr=%h data=%h ready=0",
                   mem_addr, mem_wdata, rx_ready, e[63:32], e[31:0]);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    logic took = 1'b0;
    rx_data  = b;
    rx_valid = 1'b1;
    while (!took && n < 16) begin
      took = rx_ready;
      tick(1);
      n++;
    end
    rx_valid = 1'b0;
    if (!took) begin
      tests_run++;
      fails++;
      $display("FAIL send_byte: byte %h never accepted, rx_ready=0 required 1", b);
    end
  endtask

  task automatic send_seq(input logic [7:0] seq[$]);
    foreach (seq[i]) send_byte(seq[i]);
  endtask

  task automatic push_good_writes();
    exp_q.push_back({32'h0, 32'h00A00093});
    exp_q.push_back({32'h4, 32'h01400113});
  endtask

  task automatic check_drained(input string name);
    tests_run++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL %s_writes: %0d expected writes missing, required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  // Runs the good frame and checks the done pulse, hold release and clean status.
  task automatic run_good_frame(input string name);
    int d0;
    push_good_writes();
    d0 = done_cycles;
    send_seq(good_frame);
    tests_run++;
    if ({done, cpu_hold, error} !== 3'b110) begin
      fails++;
      $display("FAIL %s_done: got done/hold/err=%b, required 110", name, {done, cpu_hold, error});
    end
    tick(1);
    tests_run++;
    if ({done, cpu_hold, error} !== 3'b000 || done_cycles - d0 != 1) begin
      fails++;
      $display("FAIL %s_after: got done/hold/err=%b pulses=%0d, required 000 pulses=1",
               name, {done, cpu_hold, error}, done_cycles - d0);
    end
    check_drained(name);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    tick(3);
    tests_run++;
    if ({rx_ready, mem_we, cpu_hold, done, error} !== 5'b10000 ||
        mem_addr !== 32'd0 || mem_wdata !== 32'd0) begin
      fails++;
      $display("FAIL reset: got rdy/we/hold/done/err=%b addr=%h data=%h, required 10000 0 0",
               {rx_ready, mem_we, cpu_hold, done, error}, mem_addr, mem_wdata);
    end
    reset = 1'b1;
    tick(2);
  endtask

  task automatic test_good_load();
    send_byte(8'hA5);
    tests_run++;
    if (cpu_hold !== 1'b1) begin
      fails++;
      $display("FAIL hold_after_sync: got %b, required 1", cpu_hold);
    end
    // Finish the frame from LEN_LO on.
    push_good_writes();
    for (int i = 1; i < 12; i++) send_byte(good_frame[i]);
    tests_run++;
    if ({done, cpu_hold} !== 2'b11) begin
      fails++;
      $display("FAIL good_done: got done/hold=%b, required 11", {done, cpu_hold});
    end
    tick(1);
    tests_run++;
    if ({done, cpu_hold, error} !== 3'b000) begin
      fails++;
      $display("FAIL good_after: got %b, required 000", {done, cpu_hold, error});
    end
    check_drained("good");
    run_good_frame("good_repeat");
  endtask

  task automatic test_bad_csum();
    logic [7:0] bad[$];
    int d0;
    bad = good_frame;
    bad[11] = 8'h61;
    push_good_writes();
    d0 = done_cycles;
    send_seq(bad);
    tick(2);
    tests_run++;
    if ({error, cpu_hold} !== 2'b11 || done_cycles != d0) begin
      fails++;
      $display("FAIL bad_csum: got err/hold=%b pulses=%0d, required 11 pulses=0",
               {error, cpu_hold}, done_cycles - d0);
    end
    check_drained("bad_csum");
    run_good_frame("recover_csum");
  endtask

  task automatic test_len_limits();
    send_seq('{8'hA5, 8'h01, 8'h01});
    tests_run++;
    if ({error, cpu_hold} !== 2'b11) begin
      fails++;
      $display("FAIL len257: got err/hold=%b, required 11", {error, cpu_hold});
    end
    tick(3);
    send_seq('{8'hA5, 8'h00, 8'h00});
    tests_run++;
    if (error !== 1'b1) begin
      fails++;
      $display("FAIL len0: got err=%b, required 1", error);
    end
    run_good_frame("recover_len");
  endtask

  task automatic test_leading_junk();
    send_seq('{8'h00, 8'hFF, 8'h13});
    tests_run++;
    if ({cpu_hold, error} !== 2'b00) begin
      fails++;
      $display("FAIL junk_idle: got hold/err=%b, required 00", {cpu_hold, error});
    end
    run_good_frame("junk");
  endtask

  task automatic test_reset_mid_frame();
    exp_q.push_back({32'h0, 32'h00A00093});
    send_seq('{8'hA5, 8'h02, 8'h00, 8'h93, 8'h00, 8'hA0, 8'h00, 8'h13, 8'h01});
    reset = 1'b0;
    tick(1);
    tests_run++;
    if ({rx_ready, mem_we, cpu_hold, done, error} !== 5'b10000 ||
        mem_addr !== 32'd0 || mem_wdata !== 32'd0) begin
      fails++;
      $display("FAIL mid_reset: got rdy/we/hold/done/err=%b addr=%h data=%h, required 10000 0 0",
               {rx_ready, mem_we, cpu_hold, done, error}, mem_addr, mem_wdata);
    end
    reset = 1'b1;
    tick(5);
    check_drained("mid_reset");
    run_good_frame("after_reset");
  endtask

  task automatic test_timeout();
    send_seq('{8'hA5, 8'h01, 8'h00, 8'h93, 8'h00});
    tick(99);
    tests_run++;
    if (error !== 1'b0) begin
      fails++;
      $display("FAIL timeout_early: got err=%b after 99 idle cycles, required 0", error);
    end
    tick(1);
    tests_run++;
    if ({error, cpu_hold} !== 2'b11) begin
      fails++;
      $display("FAIL timeout: got err/hold=%b after 100 idle cycles, required 11",
               {error, cpu_hold});
    end
    run_good_frame("recover_timeout");
  endtask

  initial begin
    test_reset();
    test_good_load();
    test_bad_csum();
    test_len_limits();
    test_leading_junk();
    test_reset_mid_frame();
    test_timeout();
    tick(3);
    check_drained("final");
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 SHALL have parameter MEM_BYTES, default 1024, meaning the size of the instruction memory in bytes (256 words).
REQ-002 SHALL have parameter SYNC_BYTE, default 8'hA5, meaning the frame start marker.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 1000000, meaning the maximum number of idle clk cycles allowed between bytes inside a frame.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all logic is on the rising edge.
REQ-005 SHALL have port reset, input, 1 bit: synchronous, active-low reset.
REQ-006 SHALL have port rx_data, input, 8 bits: received byte from the UART receiver.
REQ-007 SHALL have port rx_valid, input, 1 bit: rx_data is valid this cycle.
REQ-008 SHALL have port rx_ready, output, 1 bit: the loader accepts a byte this cycle.
REQ-009 SHALL have port mem_we, output, 1 bit: instruction-memory word write strobe.
REQ-010 SHALL have port mem_addr, output, 32 bits: byte address of the write, word-aligned.
REQ-011 SHALL have port mem_wdata, output, 32 bits: write word, little-endian assembled.
REQ-012 SHALL have port cpu_hold, output, 1 bit: holds the CPU (PC/fetch) while loading or in error.
REQ-013 SHALL have port done, output, 1 bit: one-cycle pulse on successful load.
REQ-014 SHALL have port error, output, 1 bit: level signal, high while in the ERR state.

Function
REQ-015 SHALL accept a byte only when rx_valid && rx_ready.
REQ-016 SHALL drive rx_ready=1 in every state except the cycle in which mem_we=1.
REQ-017 SHALL use the frame format: SYNC_BYTE, LEN_LO, LEN_HI (16-bit word count), 4*LEN payload bytes, CSUM (XOR of all payload bytes).
REQ-018 SHALL implement the states IDLE, LEN0, LEN1, DATA, CSUM, ERR.
REQ-019 SHALL in IDLE and ERR discard any byte other than SYNC_BYTE; on SYNC_BYTE go to LEN0, clear the checksum and counters, and clear error.
REQ-020 SHALL in LEN1 go to ERR if LEN==0 or LEN>MEM_BYTES/4; otherwise go to DATA.
REQ-021 SHALL in DATA pack bytes little-endian (first byte into bits [7:0]); on the 4th byte assert mem_we for exactly 1 cycle on the following cycle, with mem_addr=word_cnt*4 and mem_wdata set to the packed word.
REQ-022 SHALL increment word_cnt after each write; after word LEN is written, go to CSUM.
REQ-023 SHALL in CSUM, on a match, pulse done for 1 cycle and go to IDLE; on a mismatch, go to ERR.
REQ-024 SHALL NOT roll back words already written when it enters ERR.
REQ-025 SHALL restart the timeout counter on every accepted byte while in LEN0, LEN1, DATA or CSUM; at TIMEOUT_CYCLES it SHALL go to ERR.
REQ-026 SHALL hold cpu_hold=1 from acceptance of SYNC_BYTE until the done pulse (inclusive), and throughout ERR; cpu_hold SHALL be 0 in IDLE.
REQ-027 SHALL keep mem_addr and mem_wdata stable while mem_we=1; their values are don't-care otherwise.

Reset
REQ-028 SHALL, when reset=0 at a clk edge, enter IDLE and drive rx_ready=1, mem_we=0, mem_addr=0, mem_wdata=0, cpu_hold=0, done=0, error=0, with all counters and the checksum cleared.
REQ-029 SHALL abandon a frame on reset mid-frame with no further writes; a partially packed word SHALL NOT be written.

Structure
REQ-030 SHALL place the state enum, the default SYNC_BYTE and the MEM_BYTES constant in the shared package imem_loader_pkg.
REQ-031 SHALL contain one sub-module, byte_word_packer (byte shift plus 2-bit byte counter, producing word_valid).

Verification
REQ-032 SHALL cover: bytes A5 02 00 93 00 A0 00 13 01 40 01 60 -> writes (0x0, 0x00A00093) then (0x4, 0x01400113), done pulse, cpu_hold falls, error=0.
REQ-033 SHALL cover: same frame with CSUM=0x61 -> both writes occur, error=1, cpu_hold=1, no done; a following good frame clears error.
REQ-034 SHALL cover: A5 01 01 (LEN=257) -> ERR immediately after LEN_HI, no writes.
REQ-035 SHALL cover: bytes 00 FF 13 in IDLE, then a valid frame -> leading bytes ignored, load succeeds.
REQ-036 SHALL cover: reset=0 after 6 payload bytes -> one write at 0x0 only, all outputs at reset values.
REQ-037 SHALL cover: TIMEOUT_CYCLES=100, stall 100 cycles in DATA -> error=1, cpu_hold=1.
